// File: rtl/oam_dma_arbiter.sv
// Sprite DMA bus arbiter: a CPU write to DMA_REG_ADDR stalls the CPU and copies
// one 256-byte page to OAM_DATA_ADDR as alternating read/write cycles.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_mem_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_wr,
  output logic        mem_write_en,
  input  logic [7:0]  mem_data_rd,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StRead, StWrite} state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic       parity_q;

  // Reads are not arbitrated; the RAM returns data for any presented address.
  logic unused_read_en;
  assign unused_read_en = cpu_read_en;

  assign cpu_data_in = mem_data_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      parity_q <= ~parity_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    mem_addr     = 16'h0000;
    mem_data_wr  = 8'h00;
    mem_write_en = 1'b0;
    cpu_rdy      = 1'b0;
    dma_busy     = 1'b1;
    dma_done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_addr     = cpu_mem_addr;
        mem_data_wr  = cpu_data_out;
        mem_write_en = cpu_write_en;
        cpu_rdy      = 1'b1;
        dma_busy     = 1'b0;
        if (cpu_write_en && (cpu_mem_addr == DMA_REG_ADDR)) begin
          page_d  = cpu_data_out;
          idx_d   = 8'h00;
          state_d = StHalt;
        end
      end
      StHalt: begin
        mem_addr = {page_q, 8'h00};
        // Reads must land on even-parity cycles; insert ALIGN otherwise.
        state_d  = parity_q ? StRead : StAlign;
      end
      StAlign: begin
        mem_addr = {page_q, 8'h00};
        state_d  = StRead;
      end
      StRead: begin
        mem_addr = {page_q, idx_q};
        state_d  = StWrite;
      end
      StWrite: begin
        mem_addr     = OAM_DATA_ADDR;
        mem_data_wr  = mem_data_rd;
        mem_write_en = 1'b1;
        if (idx_q == 8'hFF) begin
          dma_done = 1'b1;
          state_d  = StIdle;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter with a synchronous-read RAM model and a
// per-cycle bus monitor that counts stalls, OAM writes and source accesses.
module tb_oam_dma_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_mem_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic [7:0]  cpu_data_in;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_wr;
  logic        mem_write_en;
  logic [7:0]  mem_data_rd;
  logic        dma_busy;
  logic        dma_done;

  oam_dma_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_mem_addr (cpu_mem_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_write_en (cpu_write_en),
    .cpu_read_en  (cpu_read_en),
    .cpu_data_in  (cpu_data_in),
    .cpu_rdy      (cpu_rdy),
    .mem_addr     (mem_addr),
    .mem_data_wr  (mem_data_wr),
    .mem_write_en (mem_write_en),
    .mem_data_rd  (mem_data_rd),
    .dma_busy     (dma_busy),
    .dma_done     (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    mem_data_rd <= ram[mem_addr];
    if (mem_write_en) ram[mem_addr] <= mem_data_wr;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int par      = 0;

  logic        s_rdy, s_busy, s_done, s_wen;
  logic [15:0] s_addr;
  logic [7:0]  s_wdat, s_din;

  int stall_cnt, wr_cnt, done_cnt, hdr_cnt, bad_page, low_acc;
  logic [7:0] wr_data [0:511];
  logic [7:0] exp_page;

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    s_rdy  = cpu_rdy;
    s_busy = dma_busy;
    s_done = dma_done;
    s_addr = mem_addr;
    s_wen  = mem_write_en;
    s_wdat = mem_data_wr;
    s_din  = cpu_data_in;
    if (!cpu_rdy) stall_cnt++;
    if (mem_write_en && mem_addr == 16'h2004) begin
      if (wr_cnt < 512) wr_data[wr_cnt] = mem_data_wr;
      wr_cnt++;
    end
    if (dma_done) done_cnt++;
    if (dma_busy && !mem_write_en) begin
      if (mem_addr == {exp_page, 8'h00}) hdr_cnt++;
      if (mem_addr[15:8] != exp_page) bad_page++;
    end
    if (dma_busy && mem_addr[15:8] == 8'h00) low_acc++;
    @(posedge clk);
    par = rst ? 0 : 1 - par;
    #1;
  endtask

  task automatic clear_counters();
    stall_cnt = 0;
    wr_cnt    = 0;
    done_cnt  = 0;
    hdr_cnt   = 0;
    bad_page  = 0;
    low_acc   = 0;
  endtask

  task automatic start_dma(input logic [7:0] pg, input int want_par);
    clear_counters();
    exp_page = pg;
    for (int i = 0; i < 4 && par != want_par; i++) cycle();
    cpu_write_en = 1'b1;
    cpu_mem_addr = 16'h4014;
    cpu_data_out = pg;
    cycle();
    n_checks++;
    if (s_wen !== 1'b1 || s_addr !== 16'h4014 || s_wdat !== pg || s_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL trigger_passthru: wen=%b addr=%h data=%h rdy=%b, want 1 4014 %h 1",
               s_wen, s_addr, s_wdat, s_rdy, pg);
    end
    cpu_write_en = 1'b0;
    cpu_mem_addr = 16'h0155;
    cpu_data_out = 8'hEE;
  endtask

  task automatic run_dma(input int retrig_at, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (retrig_at >= 0 && stall_cnt == retrig_at) begin
        cpu_write_en = 1'b1;
        cpu_mem_addr = 16'h4014;
        cpu_data_out = 8'h07;
      end
      cycle();
      cpu_write_en = 1'b0;
      cpu_mem_addr = 16'h0155;
      cpu_data_out = 8'hEE;
      if (s_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_dma(input string nm, input bit ok, input int exp_stall,
                           input int exp_hdr, input logic [7:0] key);
    int bad_i;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: no dma_done within 700 cycles", nm);
    end
    cycle();
    n_checks++;
    if (s_rdy !== 1'b1 || s_busy !== 1'b0 || s_addr !== 16'h0155) begin
      n_fail++;
      $display("FAIL %s_after: rdy=%b busy=%b addr=%h, want 1 0 0155", nm, s_rdy, s_busy,
               s_addr);
    end
    n_checks++;
    if (stall_cnt != exp_stall) begin
      n_fail++;
      $display("FAIL %s_stall: got %0d cycles, want %0d", nm, stall_cnt, exp_stall);
    end
    n_checks++;
    if (wr_cnt != 256) begin
      n_fail++;
      $display("FAIL %s_writes: got %0d, want 256", nm, wr_cnt);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s_done: got %0d pulses, want 1", nm, done_cnt);
    end
    n_checks++;
    if (hdr_cnt != exp_hdr) begin
      n_fail++;
      $display("FAIL %s_align: got %0d page-base cycles, want %0d", nm, hdr_cnt, exp_hdr);
    end
    n_checks++;
    if (bad_page != 0 || (exp_page != 8'h00 && low_acc != 0)) begin
      n_fail++;
      $display("FAIL %s_srcpage: off-page=%0d low=%0d, want 0 0", nm, bad_page, low_acc);
    end
    bad_i = -1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] e;
      e = i[7:0] ^ key;
      if (bad_i < 0 && wr_data[i] !== e) bad_i = i;
    end
    n_checks++;
    if (bad_i >= 0) begin
      n_fail++;
      $display("FAIL %s_data: write %0d got %h, want %h", nm, bad_i, wr_data[bad_i],
               bad_i[7:0] ^ key);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cpu_mem_addr = 16'h1357;
    cpu_data_out = 8'h42;
    cpu_write_en = 1'b0;
    cycle();
    n_checks++;
    if (s_rdy !== 1'b1 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rdy=%b busy=%b done=%b, want 1 0 0", s_rdy, s_busy, s_done);
    end
    n_checks++;
    if (s_addr !== 16'h1357 || s_wdat !== 8'h42 || s_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_passthru: addr=%h data=%h wen=%b, want 1357 42 0", s_addr, s_wdat,
               s_wen);
    end
  endtask

  task automatic test_passthrough();
    cpu_mem_addr = 16'h0200;
    cpu_read_en  = 1'b1;
    cycle();
    n_checks++;
    if (s_addr !== 16'h0200 || s_rdy !== 1'b1 || s_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_addr: addr=%h rdy=%b wen=%b, want 0200 1 0", s_addr, s_rdy, s_wen);
    end
    cycle();
    n_checks++;
    if (s_din !== 8'hA9 || s_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_data: data=%h rdy=%b, want a9 1", s_din, s_rdy);
    end
    cpu_read_en = 1'b0;
  endtask

  task automatic test_even_start();
    bit ok;
    start_dma(8'h03, 0);
    run_dma(-1, ok);
    check_dma("even", ok, 513, 2, 8'h5A);
  endtask

  task automatic test_odd_start();
    bit ok;
    start_dma(8'h03, 1);
    run_dma(-1, ok);
    check_dma("odd", ok, 514, 3, 8'h5A);
  endtask

  task automatic test_page_wrap();
    bit ok;
    start_dma(8'hFF, 0);
    run_dma(-1, ok);
    check_dma("wrap", ok, 513, 2, 8'h5A);
  endtask

  task automatic test_retrigger();
    bit ok;
    start_dma(8'h03, 0);
    run_dma(50, ok);
    check_dma("retrig", ok, 513, 2, 8'h5A);
  endtask

  task automatic test_reset_mid_dma();
    bit ok;
    start_dma(8'h03, 0);
    for (int i = 0; i < 700 && wr_cnt < 99; i++) cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    n_checks++;
    if (s_rdy !== 1'b1 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: rdy=%b busy=%b, want 1 0", s_rdy, s_busy);
    end
    for (int i = 0; i < 300; i++) cycle();
    n_checks++;
    if (wr_cnt != 100 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_writes: writes=%0d done=%0d, want 100 0", wr_cnt, done_cnt);
    end
    start_dma(8'h03, 1);
    run_dma(-1, ok);
    check_dma("restart", ok, 514, 3, 8'h5A);
  endtask

  initial begin
    rst          = 1'b1;
    cpu_mem_addr = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_write_en = 1'b0;
    cpu_read_en  = 1'b0;
    exp_page     = 8'h00;
    clear_counters();
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ram[16'h0300 + i] = i[7:0] ^ 8'h5A;
      ram[16'hFF00 + i] = i[7:0] ^ 8'h5A;
      ram[16'h0700 + i] = i[7:0] ^ 8'hC3;
    end
    ram[16'h0200] = 8'hA9;
    @(posedge clk);
    #1;
    test_reset();
    test_passthrough();
    test_even_start();
    test_odd_start();
    test_page_wrap();
    test_retrigger();
    test_reset_mid_dma();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 The block SHALL have parameter DMA_REG_ADDR, default 16'h4014: the CPU write address that triggers a DMA.
REQ-002 The block SHALL have parameter OAM_DATA_ADDR, default 16'h2004: the destination address for every DMA write.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cpu_mem_addr  in  16  CPU bus address.
- cpu_data_out  in  8  CPU write data.
- cpu_write_en  in  1  CPU write strobe.
- cpu_read_en  in  1  CPU read strobe.
- cpu_data_in  out  8  read data returned to the CPU.
- cpu_rdy  out  1  1 = CPU may advance; 0 = CPU stalled.
- mem_addr  out  16  RAM address.
- mem_data_wr  out  8  RAM write data.
- mem_write_en  out  1  RAM write strobe.
- mem_data_rd  in  8  RAM read data, valid the cycle after its address is presented.
- dma_busy  out  1  high while a DMA owns the bus.
- dma_done  out  1  one-cycle pulse on the final DMA write.

Function
REQ-005 The FSM SHALL have exactly five states: IDLE, HALT, ALIGN, READ, WRITE.
REQ-006 A 1-bit parity register SHALL toggle every clock and reset to 0.
REQ-007 cpu_data_in SHALL equal mem_data_rd combinationally in all states.
REQ-008 In IDLE, mem_addr, mem_data_wr and mem_write_en SHALL equal cpu_mem_addr, cpu_data_out and cpu_write_en combinationally, and cpu_rdy SHALL be 1.
REQ-009 In IDLE, a cycle with cpu_write_en=1 and cpu_mem_addr=DMA_REG_ADDR SHALL:
- pass the write through to RAM;
- latch page=cpu_data_out;
- clear idx to 0;
- enter HALT on the next cycle.
REQ-010 In every state other than IDLE:
- cpu_rdy SHALL be 0 and dma_busy SHALL be 1;
- CPU bus inputs SHALL be ignored, including further writes to DMA_REG_ADDR (no restart, no page change).
REQ-011 In HALT, the block SHALL drive mem_write_en=0 and mem_addr={page,8'h00}.
REQ-012 HALT SHALL go to READ if parity=1 and to ALIGN if parity=0, so every READ cycle has parity=0.
REQ-013 ALIGN SHALL drive mem_write_en=0 and mem_addr={page,8'h00}, then go to READ.
REQ-014 READ SHALL drive mem_addr={page,idx} and mem_write_en=0, then go to WRITE.
REQ-015 WRITE SHALL drive mem_addr=OAM_DATA_ADDR, mem_data_wr=mem_data_rd and mem_write_en=1.
REQ-016 In WRITE, if idx=8'hFF the block SHALL pulse dma_done=1 and go to IDLE; otherwise it SHALL increment idx and go to READ.
REQ-017 idx SHALL be 8 bits; the source address SHALL never carry into page, so page 8'hFF covers 0xFF00-0xFFFF only.
REQ-018 Stall length (cycles with cpu_rdy=0) SHALL be 513 when the trigger cycle has parity=0 and 514 when it has parity=1.
REQ-019 Each DMA SHALL perform exactly 256 writes to OAM_DATA_ADDR, in ascending source order.
REQ-020 cpu_rdy SHALL return to 1 in the cycle after the final WRITE, and IDLE pass-through SHALL resume in that same cycle.
REQ-021 All state, idx, page and parity updates SHALL occur on the rising edge of clk.
REQ-022 dma_busy and dma_done SHALL be registered or pure state decodes, with no combinational path from CPU inputs.

Reset
REQ-023 With rst=1 at a clock edge, the block SHALL set state=IDLE, page=0, idx=0, parity=0.
REQ-024 After reset, outputs SHALL be dma_busy=0, dma_done=0, cpu_rdy=1, with pass-through active.
REQ-025 A reset asserted mid-DMA SHALL abort the DMA in the next cycle: no further OAM_DATA_ADDR writes, cpu_rdy=1, and no dma_done pulse.
REQ-026 A new trigger after reset SHALL start a full 256-byte DMA from idx 0.

Verification
REQ-027 Even start: preload 0x0300+i with i^8'h5A and write 8'h03 to 0x4014 on a parity=0 cycle.
- Required: cpu_rdy=0 for exactly 513 cycles.
- Required: 256 writes to 0x2004 with data 5A,5B,58,...,A5 in order.
- Required: one dma_done pulse.
REQ-028 Odd start: repeat the REQ-027 stimulus with the trigger on a parity=1 cycle.
- Required: exactly 514 stall cycles, one ALIGN cycle, and identical write data.
REQ-029 Page wrap: trigger with page 8'hFF.
- Required: reads at 0xFF00-0xFFFF only, with no access to 0x0000-0x00FF.
REQ-030 Reset mid-DMA: assert rst=1 for one cycle during the 100th write.
- Required: exactly 100 OAM writes, cpu_rdy=1 and dma_busy=0 in the next cycle, and no dma_done pulse.
REQ-031 Retrigger during busy: write 8'h07 to 0x4014 at stall cycle 50.
- Required: ignored, exactly 256 writes, and all source addresses on the original page.
REQ-032 Pass-through: in IDLE, CPU reads 0x0200 holding 8'hA9.
- Required: mem_addr=0x0200 in the same cycle, cpu_data_in=8'hA9 the next cycle, and cpu_rdy=1 throughout.
